imem_access_sequencer: RTL
==========================

Name: imem_access_sequencer

Overview:
Sequences all accesses to the byte-wide (8-bit, big-endian) instruction memory and shares it between two requesters: the CPU fetch port and the program loader. A 32-bit fetch is issued as four byte reads and reassembled big-endian. Loader byte writes are interleaved between fetches using round-robin arbitration. The block sits between the PC/fetch logic, the boot loader and a synchronous single-port byte RAM.

Parameters:
ADDR_W, 5, byte-address width of the instruction memory.
DEPTH, 32, number of bytes implemented; valid byte addresses are 0..DEPTH-1.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
fetch_req  in  1  fetch request; held high until fetch_ack.
fetch_addr  in  32  byte address of the instruction (PC).
fetch_ack  out  1  one-cycle pulse; fetch_instr and fetch_err are valid in this cycle.
fetch_instr  out  32  assembled instruction, {byte[a], byte[a+1], byte[a+2], byte[a+3]}.
fetch_err  out  1  fetch rejected (misaligned or out of range).
load_valid  in  1  loader byte-write valid.
load_addr  in  ADDR_W  loader byte address.
load_data  in  8  loader byte.
load_ready  out  1  loader beat accepted this cycle (valid&&ready means the write occurs at this edge).
mem_en  out  1  RAM enable.
mem_we  out  1  RAM write enable.
mem_addr  out  ADDR_W  RAM byte address.
mem_wdata  out  8  RAM write data.
mem_rdata  in  8  RAM read data, valid one cycle after mem_en && !mem_we.
busy  out  1  high whenever state != IDLE.

Behaviour:
- Clocking and reset: one clock, clk. rst_n is asynchronous and active-low. On reset the block returns to IDLE immediately, whether or not an access is in progress.
- Reset values: fetch_ack=0, fetch_instr=0, fetch_err=0, load_ready=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, and the round-robin pointer favours the loader.
- States: IDLE, RD (byte counter cnt 0..3), DRAIN, DONE, ERR.
- IDLE arbitration:
  - If only one requester is active, it wins.
  - If both are active, the round-robin pointer decides. The pointer flips to the other requester after every grant.
- Loader grant in IDLE:
  - load_ready=1, mem_en=1, mem_we=1, mem_addr=load_addr, mem_wdata=load_data, all combinational.
  - The write takes one cycle and the state stays IDLE.
  - load_addr >= DEPTH: the beat is accepted but the write is suppressed (mem_en=0).
- Fetch grant in IDLE:
  - fetch_addr is captured.
  - If fetch_addr[1:0]!=0 or fetch_addr > DEPTH-4, go to ERR. Otherwise go to RD with cnt=0.
- RD:
  - mem_en=1, mem_we=0, mem_addr=base+cnt.
  - cnt increments each cycle; after cnt=3, go to DRAIN.
  - Each mem_rdata is shifted into the instruction register one cycle after its read is issued (MSB byte first).
- DRAIN: captures byte 3, then goes to DONE.
- DONE: fetch_ack=1, fetch_err=0, fetch_instr is the assembled word. Next state is IDLE.
- ERR: fetch_ack=1, fetch_err=1, fetch_instr=0, no memory access. Next state is IDLE.
- Latency, with A = the IDLE cycle that grants the fetch:
  - Reads are issued in cycles A+1..A+4.
  - A good fetch acks in cycle A+6.
  - An error fetch acks in cycle A+2.
- Atomicity: a fetch burst is never interrupted. load_ready stays 0 outside IDLE.
- fetch_req dropped mid-burst: the burst still completes and the ack still pulses.
- fetch_req held high after ack: treated as a new request in the next IDLE cycle, subject to arbitration.
- Output hold: fetch_instr holds its last value until the next DONE/ERR. fetch_ack and fetch_err are single-cycle pulses.
- Address arithmetic: base+cnt is computed in ADDR_W bits. No wrap can occur because range is checked at grant.

Decomposition:
- Shared package imem_pkg: state enum (IDLE, RD, DRAIN, DONE, ERR), 2-bit byte-count type, ERR_INSTR constant (32'h0), BYTES_PER_WORD=4.
- One natural sub-module: imem_rr_arbiter, a 2-requester round-robin arbiter with a pointer flip on grant. Used by the IDLE decision.

Test Plan:
- Load 0x08,0x00,0x00,0x03 at addresses 0..3, then fetch 0x0 -> four load_ready beats; fetch_ack exactly 6 cycles after grant with fetch_instr=0x08000003, fetch_err=0.
- Load 0x11,0x8A,0xFF,0xF8 at 28..31, then fetch 0x1C -> fetch_instr=0x118AFFF8; fetch 0x1D -> ack 2 cycles after grant with fetch_err=1, instr=0, mem_en never high.
- Fetch 0x20 with DEPTH=32 -> fetch_err=1, no RAM access. load_addr=0x20 -> load_ready=1, mem_en=0.
- load_valid and fetch_req both high in IDLE from reset -> loader granted first, then fetch, then loader. No load_ready while busy=1 during the burst.
- Continuous load_valid with repeated fetches -> grants strictly alternate loader/fetch; neither requester starves.
- Assert rst_n=0 during RD cnt=2 -> outputs reset immediately; after release, a fetch 0x0 returns the correct word with no stale bytes.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory access sequencer.
package imem_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StDrain,
        StDone,
        StErr
    } state_e;

    typedef logic [1:0] cnt_t;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam logic [31:0] ERR_INSTR      = 32'h0;
    localparam cnt_t        LAST_BYTE      = cnt_t'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/imem_access_sequencer_if.sv
// Fetch, loader and byte-RAM signals of the instruction-memory sequencer.
interface imem_access_sequencer_if #(
    parameter int unsigned ADDR_W = 5
);

    logic              fetch_req;
    logic [31:0]       fetch_addr;
    logic              fetch_ack;
    logic [31:0]       fetch_instr;
    logic              fetch_err;
    logic              load_valid;
    logic [ADDR_W-1:0] load_addr;
    logic [7:0]        load_data;
    logic              load_ready;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              busy;

    modport master (
        input  fetch_req, fetch_addr, load_valid, load_addr, load_data, mem_rdata,
        output fetch_ack, fetch_instr, fetch_err, load_ready,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport slave (
        output fetch_req, fetch_addr, load_valid, load_addr, load_data, mem_rdata,
        input  fetch_ack, fetch_instr, fetch_err, load_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );

endinterface

// File: rtl/imem_rr_arbiter.sv
// Two-requester round-robin arbiter; the pointer moves to the other side after each grant.
module imem_rr_arbiter (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req_load,
    input  logic req_fetch,
    output logic gnt_load,
    output logic gnt_fetch
);

    logic prio_load_q, prio_load_d;

    always_comb begin
        gnt_load    = 1'b0;
        gnt_fetch   = 1'b0;
        prio_load_d = prio_load_q;
        if (en) begin
            if (req_load && (!req_fetch || prio_load_q)) begin
                gnt_load = 1'b1;
            end else if (req_fetch) begin
                gnt_fetch = 1'b1;
            end
        end
        if (gnt_load) begin
            prio_load_d = 1'b0;
        end else if (gnt_fetch) begin
            prio_load_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_load_q <= 1'b1;
        end else begin
            prio_load_q <= prio_load_d;
        end
    end

endmodule

// File: rtl/imem_access_sequencer.sv
// Shares a byte-wide instruction RAM between 32-bit big-endian fetches and loader byte writes.
module imem_access_sequencer
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    imem_access_sequencer_if.master bus
);

    state_e            state_q, state_d;
    cnt_t              cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_q;
    logic [23:0]       shift_q;
    logic [31:0]       instr_q;
    logic              capture;
    logic              gnt_load, gnt_fetch;
    logic              fetch_bad;
    logic              load_in_range;

    assign fetch_bad     = (bus.fetch_addr[1:0] != 2'b00) ||
                           (bus.fetch_addr > 32'(DEPTH - BYTES_PER_WORD));
    assign load_in_range = 32'(bus.load_addr) < DEPTH;

    imem_rr_arbiter u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (state_q == StIdle),
        .req_load  (bus.load_valid),
        .req_fetch (bus.fetch_req),
        .gnt_load  (gnt_load),
        .gnt_fetch (gnt_fetch)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        capture        = 1'b0;
        bus.fetch_ack  = 1'b0;
        bus.fetch_err  = 1'b0;
        bus.load_ready = 1'b0;
        bus.mem_en     = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.busy       = (state_q != StIdle);
        unique case (state_q)
            StIdle: begin
                if (gnt_load) begin
                    bus.load_ready = 1'b1;
                    bus.mem_en     = load_in_range;
                    bus.mem_we     = 1'b1;
                    bus.mem_addr   = bus.load_addr;
                    bus.mem_wdata  = bus.load_data;
                end else if (gnt_fetch) begin
                    capture = 1'b1;
                    cnt_d   = '0;
                    state_d = fetch_bad ? StErr : StRd;
                end
            end
            StRd: begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = base_q + ADDR_W'(cnt_q);
                cnt_d        = cnt_q + 1'b1;
                if (cnt_q == LAST_BYTE) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                state_d = StDone;
            end
            StDone: begin
                bus.fetch_ack = 1'b1;
                state_d       = StIdle;
            end
            StErr: begin
                // First ERR cycle is a spacer so the error ack lands two cycles after grant.
                if (cnt_q == '0) begin
                    cnt_d = 2'd1;
                end else begin
                    bus.fetch_ack = 1'b1;
                    bus.fetch_err = 1'b1;
                    state_d       = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.fetch_instr = instr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            base_q  <= '0;
            shift_q <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                base_q <= bus.fetch_addr[ADDR_W-1:0];
            end
            // Read data lags its address by one cycle, so byte 0 arrives at cnt=1.
            if ((state_q == StRd && cnt_q != '0) || state_q == StDrain) begin
                shift_q <= {shift_q[15:0], bus.mem_rdata};
            end
            if (state_q == StDrain) begin
                instr_q <= {shift_q, bus.mem_rdata};
            end else if (state_q == StErr && cnt_q == '0) begin
                instr_q <= ERR_INSTR;
            end
        end
    end

endmodule
